conv_result_collector: RTL and testbench
========================================

Name: conv_result_collector

Overview:
- Sink-side partner of the convolution engine. Consumes the engine's result/valid stream, which has no backpressure, and buffers it in a FIFO.
- Re-emits results on a valid/ready stream toward writeback, tagged with output-frame position (last-column, last-of-frame).
- Counts drops when downstream stalls too long, and flags frame completion.

Parameters:
- OUT_WIDTH, 32, width of one convolution result (matches engine OUT_WIDTH).
- DEPTH, 16, FIFO entries; power of two, >= 2.
- OUT_COLS, 30, results per output row.
- OUT_ROWS, 30, output rows per frame.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- result  in  OUT_WIDTH  convolution result from the engine.
- valid  in  1  result qualifier; one result per high cycle; no ready is returned.
- clear  in  1  synchronous: flushes the FIFO, zeroes the position counters, clears overflow and drop_cnt.
- m_data  out  OUT_WIDTH  head-of-FIFO result.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last_col  out  1  m_data is the last result of its row.
- m_last  out  1  m_data is the last result of the frame.
- frame_done  out  1  one-cycle pulse after the frame's final result is accepted.
- overflow  out  1  sticky: at least one result was dropped.
- drop_cnt  out  16  dropped-result count; saturates at 16'hFFFF.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (async assert, sync release):
- Clears pointers, level, col_cnt, row_cnt, overflow and drop_cnt.
- m_valid, m_last_col, m_last and frame_done = 0; m_data = 0.

Handshake:
- push = valid && (level < DEPTH || pop).
- pop = m_valid && m_ready.
- First-word-fall-through, registered: a push into an empty FIFO at edge N gives m_valid = 1 after edge N (visible cycle N+1). There is no combinational path from valid to m_valid.
- While m_valid is high, m_data, m_last_col and m_last hold stable until pop.
- Push and pop in the same cycle: level unchanged. This is legal at full, so a full FIFO with m_ready high drops nothing.

Overflow:
- valid high, level == DEPTH and no pop: result discarded, FIFO contents unchanged.
- overflow set (sticky); drop_cnt += 1, saturating.

Position tracking:
- col_cnt and row_cnt count popped (not pushed) results.
- m_last_col = (col_cnt == OUT_COLS-1).
- m_last = m_last_col && (row_cnt == OUT_ROWS-1).
- On pop: col_cnt wraps to 0 at OUT_COLS-1 and row_cnt increments. When m_last, both wrap to 0.
- frame_done = 1 for exactly the cycle after the pop of the m_last result.
- Dropped results do not advance the counters, so a frame with drops ends late. Host detects this via overflow.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- level is tracked separately; no full/empty ambiguity.

clear:
- Takes priority over push and pop in the same cycle.
- The next cycle has the reset state, except frame_done = 0 regardless.

Reset mid-frame:
- Everything returns to the reset state immediately.
- The partially delivered frame is abandoned; no frame_done.

Optional Feature:
- CONV_COLLECT_RELU_EN
  - Defined: result is interpreted as two's complement; a negative value (MSB = 1) is stored as 0 at push time. Non-negative values pass unchanged.
  - Undefined: result is stored bit-exact.
- Counting, overflow and handshake behaviour are identical in both builds.

Test Plan:
- Basic flow: reset, m_ready = 1, push 32'h0000_0005 at edge N -> m_valid = 1 and m_data = 5 at cycle N+1; level returns to 0 after the pop.
- Frame tagging: OUT_COLS = 3, OUT_ROWS = 2, push 6 results 1..6 with m_ready = 1 -> m_last_col high on 3 and 6; m_last high only on 6; frame_done pulses once, the cycle after 6 is accepted.
- Overflow: m_ready = 0, push DEPTH+3 = 19 results -> level = 16, overflow = 1, drop_cnt = 3. Then drain with m_ready = 1 -> 16 values out in order 1..16.
- Full with simultaneous pop: fill to 16, then hold valid and m_ready high for 10 cycles -> level stays 16, drop_cnt = 0, outputs in order.
- clear and reset mid-frame: after 4 of 6 pops, pulse clear (or assert rst asynchronously mid-cycle) -> m_valid = 0, level = 0 and counters 0. The next result pushed is tagged as column 0, row 0.
- CONV_COLLECT_RELU_EN: push 32'hFFFF_FFF0 then 32'h0000_0007 -> with the macro defined, out 0 then 7; without it, out FFFF_FFF0 then 7.

Source files
------------

// File: rtl/conv_result_collector_if.sv
// Stream bundle between the convolution engine, the result collector and writeback.
// master = collector side (sinks the engine stream, sources the tagged m_ stream); slave = environment side.
interface conv_result_collector_if #(
    parameter int OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0] result;
    logic                 valid;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last_col;
    logic                 m_last;

    modport master (
        input  result, valid, m_ready,
        output m_data, m_valid, m_last_col, m_last
    );

    modport slave (
        output result, valid, m_ready,
        input  m_data, m_valid, m_last_col, m_last
    );
endinterface

// File: rtl/conv_result_collector.sv
// Buffers the engine's no-backpressure result stream in a FIFO and re-emits it valid/ready, tagged with row/frame end.
// Latency: registered first-word-fall-through, one cycle from push to m_valid. Backpressure: none upstream; when full without a pop, results are dropped and counted.
// Build option: CONV_COLLECT_RELU_EN clamps negative results to zero at push time.
module conv_result_collector #(
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int OUT_COLS  = 30,
    parameter int OUT_ROWS  = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    conv_result_collector_if.master  bus,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam logic [LW-1:0] FULL    = LW'(DEPTH);
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_ROWS - 1);

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        col_cnt;
    logic [RW-1:0]        row_cnt;
    logic [OUT_WIDTH-1:0] wdata;
    logic                 push;
    logic                 pop;
    logic                 at_col_end;
    logic                 at_row_end;

    assign pop  = bus.m_valid && bus.m_ready;
    assign push = bus.valid && ((level < FULL) || pop);

    always_comb begin
`ifdef CONV_COLLECT_RELU_EN
        wdata = bus.result[OUT_WIDTH-1] ? '0 : bus.result;
`else
        wdata = bus.result;
`endif
    end

    // Head is read straight out of storage; level is a register, so valid never reaches m_valid combinationally.
    assign bus.m_valid    = (level != '0);
    assign bus.m_data     = bus.m_valid ? mem[rd_ptr] : '0;
    assign at_col_end     = (col_cnt == COL_MAX);
    assign at_row_end     = (row_cnt == ROW_MAX);
    assign bus.m_last_col = bus.m_valid && at_col_end;
    assign bus.m_last     = bus.m_valid && at_col_end && at_row_end;

    // At full with a simultaneous pop, wr_ptr equals rd_ptr: the head leaves on the same edge it is overwritten.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end

            if (bus.valid && !push) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end

            frame_done <= pop && bus.m_last;

            // Position advances on delivery, not arrival, so drops shift the frame end rather than corrupt tags.
            if (pop) begin
                if (at_col_end) begin
                    col_cnt <= '0;
                    row_cnt <= at_row_end ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector (DEPTH=16, 3x2 frame); expected results go through a scoreboard queue.
module tb_conv_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    conv_result_collector_if #(.OUT_WIDTH(32)) bus ();

    conv_result_collector #(
        .OUT_WIDTH(32), .DEPTH(16), .OUT_COLS(3), .OUT_ROWS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bus        (bus),
        .frame_done (frame_done),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        lc;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pos = 0;
    int   fd_count = 0;
    logic fd_exp = 1'b0;
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_COLLECT_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Drives one result for the next edge; kept=1 means the FIFO is expected to accept it.
    task automatic push(input logic [31:0] v, input bit kept);
        exp_t x;
        @(posedge clk); #1;
        bus.valid  = 1'b1;
        bus.result = v;
        if (kept) begin
            x.d  = relu(v);
            x.lc = (pos % 3 == 2);
            x.l  = (pos == 5);
            q.push_back(x);
            pos = (pos + 1) % 6;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.valid = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear     = 1'b1;
        bus.valid = 1'b0;
        q.delete();
        pos = 0;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear_m_valid", 32'(bus.m_valid), 32'd0);
        check("clear_level", 32'(level), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        while ((q.size() != 0 || bus.m_valid) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 32'(q.size()), 32'd0);
        check({name, "_level0"}, 32'(level), 32'd0);
    endtask

    // Monitor: every accepted word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            fd_exp = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            if (frame_done) fd_count++;
            fd_exp = 1'b0;
            if (!clear && bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_pop: got %h expected no output", bus.m_data);
                end else begin
                    e = q.pop_front();
                    check("m_data", bus.m_data, e.d);
                    check("m_last_col", 32'(bus.m_last_col), 32'(e.lc));
                    check("m_last", 32'(bus.m_last), 32'(e.l));
                    fd_exp = e.l;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        bus.valid   = 1'b0;
        bus.result  = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", bus.m_data, 32'd0);
        check("rst_m_last_col", 32'(bus.m_last_col), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Basic flow: visible the cycle after the push edge
        bus.m_ready = 1'b1;
        push(32'h5, 1'b1);
        idle();
        @(negedge clk);
        check("basic_m_valid", 32'(bus.m_valid), 32'd1);
        check("basic_m_data", bus.m_data, 32'h5);
        @(negedge clk);
        check("basic_level", 32'(level), 32'd0);

        // Frame tagging
        do_clear();
        fd0 = fd_count;
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) push(32'(i), 1'b1);
        idle();
        drain("tag");
        repeat (2) @(negedge clk);
        check("tag_fd_pulses", 32'(fd_count - fd0), 32'd1);

        // Overflow: 19 pushes into a stalled 16-deep FIFO
        do_clear();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 19; i++) push(32'(i), i <= 16);
        idle();
        @(negedge clk);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous pop drops nothing
        do_clear();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(32'(i), 1'b1);
        idle();
        @(negedge clk);
        check("full_level", 32'(level), 32'd16);
        for (int i = 0; i < 10; i++) begin
            push(32'(17 + i), 1'b1);
            bus.m_ready = 1'b1;
            @(negedge clk);
            check("full_pp_level", 32'(level), 32'd16);
        end
        idle();
        @(negedge clk);
        check("full_pp_level_end", 32'(level), 32'd16);
        check("full_pp_drop_cnt", 32'(drop_cnt), 32'd0);
        check("full_pp_overflow", 32'(overflow), 32'd0);
        drain("full");

        // clear mid-frame: 4 delivered, 2 queued, then clear
        do_clear();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b1);
        idle();
        repeat (3) @(negedge clk);
        bus.m_ready = 1'b0;
        push(32'h5, 1'b1);
        push(32'h6, 1'b1);
        idle();
        @(negedge clk);
        check("mid_level_pre", 32'(level), 32'd2);
        do_clear();
        bus.m_ready = 1'b1;
        for (int i = 7; i <= 9; i++) push(32'(i), 1'b1);
        idle();
        drain("clr_restart");

        // Asynchronous reset mid-frame
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b1);
        idle();
        repeat (3) @(negedge clk);
        bus.m_ready = 1'b0;
        push(32'h5, 1'b1);
        idle();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 32'(bus.m_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_m_data", bus.m_data, 32'd0);
        q.delete();
        pos = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 7; i <= 9; i++) push(32'(i), 1'b1);
        idle();
        drain("rst_restart");

        // Negative-value handling (build dependent)
        do_clear();
        bus.m_ready = 1'b1;
        push(32'hFFFF_FFF0, 1'b1);
        push(32'h7, 1'b1);
        idle();
        drain("relu");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
